cnt_disp_drv: RTL and testbench

CNT_DISP_DRV -- requirements
Module: cnt_disp_drv

---
 rtl/cnt_disp_pkg.sv | 30 +++
 rtl/cnt_disp_drv_seg7_dec.sv | 29 ++
 rtl/cnt_disp_drv.sv | 179 +++++++++++++++++
 tb/tb_cnt_disp_drv.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/cnt_disp_pkg.sv
// cnt_disp_pkg: shared types and constants for the count display driver.
//   cvt_state_e : state encoding of the binary-to-BCD conversion FSM.
//   SEG_*       : active-high 7-segment patterns, bit [0]=a ... bit [6]=g.
//   DIG_BLANK   : digit code that decodes to an unlit display position.
//   DIG_ERR     : digit code shown on a range error (decodes to a dash).
package cnt_disp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } cvt_state_e;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_DASH  = 7'b1000000;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  localparam logic [3:0] DIG_BLANK = 4'hA;
  localparam logic [3:0] DIG_ERR   = 4'hF;

endpackage

// File: rtl/cnt_disp_drv_seg7_dec.sv
// seg7_dec: combinational 4-bit digit to 7-segment decode, active-high.
//   digit : 0-9 decode to numerals, 4'hF to a dash, 10-14 to blank.
//   seg   : segments a..g in bit order [0]..[6], 1 = lit.
module seg7_dec
  import cnt_disp_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      4'hF:    seg = SEG_DASH;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/cnt_disp_drv.sv
// cnt_disp_drv: converts a binary count (0..COUNT_MAX) to two BCD digits by
// repeated subtraction and drives a 2-digit multiplexed 7-segment display.
//   clk, rst  : single clock, synchronous active-high reset.
//   cnt_in    : binary count, may change on any cycle.
//   bcd_tens  : registered tens digit (4'hF on range error).
//   bcd_ones  : registered ones digit (4'hF on range error).
//   cvt_busy  : conversion FSM not idle.
//   range_err : last completed conversion was out of range.
//   seg       : segments a..g, [0]..[6], polarity set by SEG_ACTIVE_LOW.
//   dig_sel   : one-hot digit enable, 2'b01 ones, 2'b10 tens.
module cnt_disp_drv
  import cnt_disp_pkg::*;
#(
  parameter int COUNT_MAX      = 59,
  parameter int SCAN_DIV       = 50,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int LZ_BLANK       = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] cnt_in,
  output logic [3:0] bcd_tens,
  output logic [3:0] bcd_ones,
  output logic       cvt_busy,
  output logic       range_err,
  output logic [6:0] seg,
  output logic [1:0] dig_sel
);

  localparam int         SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [6:0] MAX_V   = 7'(COUNT_MAX);
  localparam logic [6:0] SEG_RST = (SEG_ACTIVE_LOW != 0) ? ~SEG_0 : SEG_0;

  cvt_state_e        state_q, state_d;
  logic [6:0]        last_seen_q, last_seen_d;
  logic [6:0]        rem_q, rem_d;
  logic [3:0]        tens_q, tens_d;
  logic [6:0]        pend_q, pend_d;
  logic              pend_v_q, pend_v_d;
  logic [3:0]        bcd_tens_q, bcd_tens_d;
  logic [3:0]        bcd_ones_q, bcd_ones_d;
  logic              range_err_q, range_err_d;
  logic              cvt_busy_q, cvt_busy_d;
  logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
  logic [1:0]        dig_sel_q, dig_sel_d;
  logic [6:0]        seg_q, seg_d;

  logic              change;
  logic              cap_en;
  logic [6:0]        cap_val;
  logic              scan_wrap;
  logic [3:0]        disp_digit;
  logic [6:0]        dec_seg;

  // Conversion FSM next-state logic
  always_comb begin
    change      = (cnt_in != last_seen_q);
    state_d     = state_q;
    last_seen_d = change ? cnt_in : last_seen_q;
    rem_d       = rem_q;
    tens_d      = tens_q;
    pend_d      = pend_q;
    pend_v_d    = pend_v_q;
    bcd_tens_d  = bcd_tens_q;
    bcd_ones_d  = bcd_ones_q;
    range_err_d = range_err_q;
    cap_en      = 1'b0;
    cap_val     = cnt_in;

    case (state_q)
      IDLE: begin
        cap_en = change;
      end
      SUB: begin
        // A change mid-conversion is parked; only the newest survives.
        if (change) begin
          pend_d   = cnt_in;
          pend_v_d = 1'b1;
        end
        if (rem_q >= 7'd10) begin
          rem_d  = rem_q - 7'd10;
          tens_d = tens_q + 4'd1;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        // Out-of-range captures bypass SUB, so rem still holds the raw value.
        if (rem_q > MAX_V) begin
          bcd_tens_d  = DIG_ERR;
          bcd_ones_d  = DIG_ERR;
          range_err_d = 1'b1;
        end else begin
          bcd_tens_d  = tens_q;
          bcd_ones_d  = rem_q[3:0];
          range_err_d = 1'b0;
        end
        if (change) begin
          cap_en   = 1'b1;
          pend_v_d = 1'b0;
        end else if (pend_v_q) begin
          cap_en   = 1'b1;
          cap_val  = pend_q;
          pend_v_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (cap_en) begin
      rem_d   = cap_val;
      tens_d  = 4'd0;
      state_d = (cap_val > MAX_V) ? DONE : SUB;
    end

    cvt_busy_d = (state_d != IDLE);
  end

  // Display scan: digit enable and segment data move on the same edge
  always_comb begin
    scan_wrap  = (scan_cnt_q == SCAN_W'(SCAN_DIV - 1));
    scan_cnt_d = scan_wrap ? '0 : scan_cnt_q + SCAN_W'(1);
    dig_sel_d  = scan_wrap ? {dig_sel_q[0], dig_sel_q[1]} : dig_sel_q;
    if (dig_sel_d[1]) begin
      disp_digit = ((LZ_BLANK != 0) && (bcd_tens_q == 4'd0)) ? DIG_BLANK : bcd_tens_q;
    end else begin
      disp_digit = bcd_ones_q;
    end
    seg_d = (SEG_ACTIVE_LOW != 0) ? ~dec_seg : dec_seg;
  end

  seg7_dec u_seg7_dec (
    .digit (disp_digit),
    .seg   (dec_seg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      last_seen_q <= 7'd0;
      pend_v_q    <= 1'b0;
      bcd_tens_q  <= 4'd0;
      bcd_ones_q  <= 4'd0;
      range_err_q <= 1'b0;
      cvt_busy_q  <= 1'b0;
      scan_cnt_q  <= '0;
      dig_sel_q   <= 2'b01;
      seg_q       <= SEG_RST;
    end else begin
      state_q     <= state_d;
      last_seen_q <= last_seen_d;
      pend_v_q    <= pend_v_d;
      bcd_tens_q  <= bcd_tens_d;
      bcd_ones_q  <= bcd_ones_d;
      range_err_q <= range_err_d;
      cvt_busy_q  <= cvt_busy_d;
      scan_cnt_q  <= scan_cnt_d;
      dig_sel_q   <= dig_sel_d;
      seg_q       <= seg_d;
    end
  end

  // Datapath working registers are qualified by the FSM state
  always_ff @(posedge clk) begin
    rem_q  <= rem_d;
    tens_q <= tens_d;
    pend_q <= pend_d;
  end

  assign bcd_tens  = bcd_tens_q;
  assign bcd_ones  = bcd_ones_q;
  assign cvt_busy  = cvt_busy_q;
  assign range_err = range_err_q;
  assign seg       = seg_q;
  assign dig_sel   = dig_sel_q;

endmodule

// File: tb/tb_cnt_disp_drv.sv
// Directed bench for cnt_disp_drv: default configuration plus an
// LZ_BLANK=1 instance sharing the same clock, reset and count input.
module tb_cnt_disp_drv;

  logic       clk;
  logic       rst;
  logic [6:0] cnt_in;

  logic [3:0] bcd_tens, bcd_ones;
  logic       cvt_busy, range_err;
  logic [6:0] seg;
  logic [1:0] dig_sel;

  logic [3:0] lz_bcd_tens, lz_bcd_ones;
  logic       lz_cvt_busy, lz_range_err;
  logic [6:0] lz_seg;
  logic [1:0] lz_dig_sel;

  int checks = 0;
  int errors = 0;

  localparam logic [6:0] AL_0     = 7'b1000000;
  localparam logic [6:0] AL_7     = 7'b1111000;
  localparam logic [6:0] AL_9     = 7'b0010000;
  localparam logic [6:0] AL_DASH  = 7'b0111111;
  localparam logic [6:0] AL_BLANK = 7'b1111111;

  cnt_disp_drv dut (
    .clk       (clk),
    .rst       (rst),
    .cnt_in    (cnt_in),
    .bcd_tens  (bcd_tens),
    .bcd_ones  (bcd_ones),
    .cvt_busy  (cvt_busy),
    .range_err (range_err),
    .seg       (seg),
    .dig_sel   (dig_sel)
  );

  cnt_disp_drv #(.LZ_BLANK(1)) dut_lz (
    .clk       (clk),
    .rst       (rst),
    .cnt_in    (cnt_in),
    .bcd_tens  (lz_bcd_tens),
    .bcd_ones  (lz_bcd_ones),
    .cvt_busy  (lz_cvt_busy),
    .range_err (lz_range_err),
    .seg       (lz_seg),
    .dig_sel   (lz_dig_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    logic [1:0] exp_sel;
    logic       seen_tens, seen_ones;

    // Reset held for two cycles with count at zero
    rst    = 1'b1;
    cnt_in = 7'd0;
    tick();
    tick();
    check("rst_tens", 32'(bcd_tens), 32'd0);
    check("rst_ones", 32'(bcd_ones), 32'd0);
    check("rst_busy", 32'(cvt_busy), 32'd0);
    check("rst_err", 32'(range_err), 32'd0);
    check("rst_dig_sel", 32'(dig_sel), 32'b01);
    check("rst_seg", 32'(seg), 32'(AL_0));
    rst = 1'b0;

    // Idle scanning with count 0: no conversion, digit swaps every 50 cycles
    for (int k = 1; k <= 120; k++) begin
      tick();
      exp_sel = (((k / 50) % 2) == 1) ? 2'b10 : 2'b01;
      check("idle_busy", 32'(cvt_busy), 32'd0);
      check("idle_dig_sel", 32'(dig_sel), 32'(exp_sel));
      check("idle_seg", 32'(seg), 32'(AL_0));
    end
    check("idle_tens", 32'(bcd_tens), 32'd0);
    check("idle_ones", 32'(bcd_ones), 32'd0);

    // 0 -> 59: busy for 7 cycles, result on capture edge + 7
    cnt_in = 7'd59;
    for (int i = 0; i < 7; i++) begin
      tick();
      check("c59_busy", 32'(cvt_busy), 32'd1);
      check("c59_hold", 32'({bcd_tens, bcd_ones}), 32'h00);
    end
    tick();
    check("c59_busy_end", 32'(cvt_busy), 32'd0);
    check("c59_bcd", 32'({bcd_tens, bcd_ones}), 32'h59);
    tick();
    check("c59_seg_ones", 32'(seg), 32'(AL_9));

    // 45 captured, 46 then 47 arrive during SUB: 4/6 must never show
    cnt_in = 7'd45;
    tick();
    cnt_in = 7'd46;
    tick();
    cnt_in = 7'd47;
    tick();
    for (int i = 3; i <= 11; i++) begin
      tick();
      check("pend_seq", 32'({bcd_tens, bcd_ones}), (i < 6) ? 32'h59 : 32'h45);
    end
    tick();
    check("pend_final", 32'({bcd_tens, bcd_ones}), 32'h47);
    check("pend_busy", 32'(cvt_busy), 32'd0);

    // Out-of-range 72 then recovery with 3
    cnt_in = 7'd72;
    tick();
    check("oor_busy", 32'(cvt_busy), 32'd1);
    tick();
    check("oor_bcd", 32'({bcd_tens, bcd_ones}), 32'hFF);
    check("oor_err", 32'(range_err), 32'd1);
    tick();
    check("oor_seg", 32'(seg), 32'(AL_DASH));
    cnt_in = 7'd3;
    tick();
    check("rec_err_hold0", 32'(range_err), 32'd1);
    tick();
    check("rec_err_hold1", 32'(range_err), 32'd1);
    check("rec_bcd_hold", 32'({bcd_tens, bcd_ones}), 32'hFF);
    tick();
    check("rec_bcd", 32'({bcd_tens, bcd_ones}), 32'h03);
    check("rec_err", 32'(range_err), 32'd0);

    // Reset two cycles after capturing 58, with a pending value queued
    cnt_in = 7'd58;
    tick();
    cnt_in = 7'd57;
    tick();
    check("mid_pend_v", 32'(dut.pend_v_q), 32'd1);
    rst = 1'b1;
    tick();
    check("mid_rst_bcd", 32'({bcd_tens, bcd_ones}), 32'h00);
    check("mid_rst_busy", 32'(cvt_busy), 32'd0);
    check("mid_rst_pend_v", 32'(dut.pend_v_q), 32'd0);
    check("mid_rst_dig_sel", 32'(dig_sel), 32'b01);
    check("mid_rst_seg", 32'(seg), 32'(AL_0));
    rst    = 1'b0;
    cnt_in = 7'd0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("post_rst_busy", 32'(cvt_busy), 32'd0);
    end
    check("post_rst_bcd", 32'({bcd_tens, bcd_ones}), 32'h00);

    // Leading-zero blanking on the LZ_BLANK=1 instance with count 7
    cnt_in = 7'd7;
    tick();
    tick();
    check("lz_bcd_hold", 32'({lz_bcd_tens, lz_bcd_ones}), 32'h00);
    tick();
    check("lz_bcd", 32'({lz_bcd_tens, lz_bcd_ones}), 32'h07);
    check("nolz_bcd", 32'({bcd_tens, bcd_ones}), 32'h07);
    tick();
    seen_tens = 1'b0;
    seen_ones = 1'b0;
    for (int i = 0; i < 110; i++) begin
      tick();
      if (lz_dig_sel == 2'b10) begin
        seen_tens = 1'b1;
        check("lz_tens_seg", 32'(lz_seg), 32'(AL_BLANK));
        check("nolz_tens_seg", 32'(seg), 32'(AL_0));
      end else begin
        seen_ones = 1'b1;
        check("lz_ones_sel", 32'(lz_dig_sel), 32'b01);
        check("lz_ones_seg", 32'(lz_seg), 32'(AL_7));
        check("nolz_ones_seg", 32'(seg), 32'(AL_7));
      end
    end
    check("lz_both_slots", 32'({seen_tens, seen_ones}), 32'b11);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
